aux_tx_mux: RTL and testbench

- Downstream stage of the I2C-over-AUX path. Consumes byte streams from the native-AUX encoder and the I2C message encoder (i2c_splitted_msg / i2c_msg_vld).
- Arbitrates between the two sources and buffers one complete request message in an internal FIFO.
- Streams the message to the AUX PHY serializer over a valid/ready handshake, marking the last byte.
- Exactly one request message is in flight at a time. Upstream FSMs wait for a reply before issuing the next message.

---
 rtl/aux_tx_pkg.sv | 12 +
 rtl/aux_tx_fifo.sv | 51 +++++
 rtl/aux_tx_mux.sv | 124 ++++++++++++
 tb/tb_aux_tx_mux.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aux_tx_pkg.sv
// Shared types and constants for the AUX transmit mux and its byte FIFO.
package aux_tx_pkg;

  typedef enum logic [1:0] {IDLE, COLLECT, SEND} aux_tx_state_e;

  localparam logic SRC_NATIVE = 1'b0;
  localparam logic SRC_I2C    = 1'b1;

  localparam int unsigned AUX_MIN_MSG_LEN = 3;
  localparam int unsigned BYTE_W          = 8;

endpackage

// File: rtl/aux_tx_fifo.sv
// Single-message byte FIFO with flush, first-word-fall-through read and occupancy count.
module aux_tx_fifo
  import aux_tx_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [BYTE_W-1:0] rd_data,
  output logic [AW:0]       count
);

  localparam int unsigned CNT_W = AW + 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  // Storage carries no reset; stale bytes are never observable past count.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/aux_tx_mux.sv
// Arbitrates native-AUX and I2C byte streams into one buffered message and streams it to the PHY.
// Optional AUX_TX_MIN_LEN_EN discards messages shorter than an address-only header.
module aux_tx_mux
  import aux_tx_pkg::*;
#(
  parameter int unsigned DEPTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] native_splitted_msg,
  input  logic       native_msg_vld,
  input  logic [7:0] i2c_splitted_msg,
  input  logic       i2c_msg_vld,
  input  logic       aux_tx_rdy,
  output logic [7:0] aux_tx_data,
  output logic       aux_tx_vld,
  output logic       aux_tx_last,
  output logic       aux_tx_src,
  output logic       aux_tx_busy,
  output logic       aux_tx_err
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  aux_tx_state_e     state, state_next;
  logic              src, src_next;
  logic              err_next;
  logic              flush, wr_en, rd_en;
  logic [BYTE_W-1:0] wr_data, rd_data;
  logic [AW:0]       count;
  logic              lock_vld, other_vld;
  logic [BYTE_W-1:0] lock_data;

  aux_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .count   (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      src        <= SRC_NATIVE;
      aux_tx_err <= 1'b0;
    end else begin
      state      <= state_next;
      src        <= src_next;
      aux_tx_err <= err_next;
    end
  end

  // Native has priority on a tie; every dropped byte funnels into a single err pulse.
  always_comb begin
    state_next = state;
    src_next   = src;
    err_next   = 1'b0;
    flush      = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    wr_data    = native_splitted_msg;
    lock_vld   = (src == SRC_I2C) ? i2c_msg_vld : native_msg_vld;
    other_vld  = (src == SRC_I2C) ? native_msg_vld : i2c_msg_vld;
    lock_data  = (src == SRC_I2C) ? i2c_splitted_msg : native_splitted_msg;
    case (state)
      IDLE: begin
        if (native_msg_vld) begin
          wr_en      = 1'b1;
          src_next   = SRC_NATIVE;
          err_next   = i2c_msg_vld;
          state_next = COLLECT;
        end else if (i2c_msg_vld) begin
          wr_en      = 1'b1;
          wr_data    = i2c_splitted_msg;
          src_next   = SRC_I2C;
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        wr_data  = lock_data;
        err_next = other_vld;
        if (lock_vld) begin
          if (count == CNT_W'(DEPTH)) begin
            flush      = 1'b1;
            err_next   = 1'b1;
            state_next = IDLE;
          end else begin
            wr_en = 1'b1;
          end
        end else begin
`ifdef AUX_TX_MIN_LEN_EN
          if (count < CNT_W'(AUX_MIN_MSG_LEN)) begin
            flush      = 1'b1;
            err_next   = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = SEND;
          end
`else
          state_next = SEND;
`endif
        end
      end
      SEND: begin
        err_next = native_msg_vld | i2c_msg_vld;
        rd_en    = aux_tx_rdy;
        if (aux_tx_rdy && count == CNT_W'(1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign aux_tx_vld  = (state == SEND);
  assign aux_tx_data = aux_tx_vld ? rd_data : 8'h00;
  assign aux_tx_last = aux_tx_vld && (count == CNT_W'(1));
  assign aux_tx_src  = src;
  assign aux_tx_busy = (state != IDLE);

endmodule

// File: tb/tb_aux_tx_mux.sv
// Directed-vector bench for aux_tx_mux: one task per scenario with inline expected values.
module tb_aux_tx_mux;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] native_splitted_msg;
  logic       native_msg_vld;
  logic [7:0] i2c_splitted_msg;
  logic       i2c_msg_vld;
  logic       aux_tx_rdy;
  logic [7:0] aux_tx_data;
  logic       aux_tx_vld;
  logic       aux_tx_last;
  logic       aux_tx_src;
  logic       aux_tx_busy;
  logic       aux_tx_err;

  int vectors     = 0;
  int miscompares = 0;
  int err_count   = 0;
  int vld_seen    = 0;
  int pop_count   = 0;

  always #5 clk = ~clk;

  aux_tx_mux #(.DEPTH(32)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .native_splitted_msg (native_splitted_msg),
    .native_msg_vld      (native_msg_vld),
    .i2c_splitted_msg    (i2c_splitted_msg),
    .i2c_msg_vld         (i2c_msg_vld),
    .aux_tx_rdy          (aux_tx_rdy),
    .aux_tx_data         (aux_tx_data),
    .aux_tx_vld          (aux_tx_vld),
    .aux_tx_last         (aux_tx_last),
    .aux_tx_src          (aux_tx_src),
    .aux_tx_busy         (aux_tx_busy),
    .aux_tx_err          (aux_tx_err)
  );

  // Event counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (aux_tx_err) err_count++;
    if (aux_tx_vld) vld_seen++;
    if (aux_tx_vld && aux_tx_rdy) pop_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    native_splitted_msg = 8'h00; native_msg_vld = 1'b0;
    i2c_splitted_msg = 8'h00; i2c_msg_vld = 1'b0; aux_tx_rdy = 1'b0;
    tick(); tick();
    vectors++;
    if ({aux_tx_data, aux_tx_vld, aux_tx_last, aux_tx_src, aux_tx_busy, aux_tx_err} !== 13'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got data=%h vld=%b last=%b src=%b busy=%b err=%b want all 0",
               aux_tx_data, aux_tx_vld, aux_tx_last, aux_tx_src, aux_tx_busy, aux_tx_err);
    end
    vectors++;
    if (dut.u_fifo.count !== 6'd0) begin
      miscompares++; $display("FAIL reset_count: got %0d want 0", dut.u_fifo.count);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if ({aux_tx_vld, aux_tx_busy} !== 2'b00) begin
      miscompares++; $display("FAIL reset_release: got vld=%b busy=%b want 0 0", aux_tx_vld, aux_tx_busy);
    end
  endtask

  task automatic test_i2c_msg();
    logic [7:0] msg [4];
    int base_err;
    msg = '{8'h40, 8'h00, 8'h50, 8'h00};
    base_err = err_count;
    for (int i = 0; i < 4; i++) begin
      i2c_msg_vld = 1'b1; i2c_splitted_msg = msg[i];
      tick();
      vectors++;
      if ({aux_tx_vld, aux_tx_busy} !== 2'b01) begin
        miscompares++; $display("FAIL i2c_collect[%0d]: got vld=%b busy=%b want 0 1", i, aux_tx_vld, aux_tx_busy);
      end
    end
    i2c_msg_vld = 1'b0; i2c_splitted_msg = 8'h00; aux_tx_rdy = 1'b1;
    tick();
    vectors++;
    if ({aux_tx_vld, aux_tx_src} !== 2'b11) begin
      miscompares++; $display("FAIL i2c_latency: got vld=%b src=%b want 1 1", aux_tx_vld, aux_tx_src);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({aux_tx_vld, aux_tx_data, aux_tx_last} !== {1'b1, msg[i], (i == 3)}) begin
        miscompares++;
        $display("FAIL i2c_byte[%0d]: got vld=%b data=%h last=%b want 1 %h %b",
                 i, aux_tx_vld, aux_tx_data, aux_tx_last, msg[i], (i == 3));
      end
      tick();
    end
    aux_tx_rdy = 1'b0;
    vectors++;
    if ({aux_tx_vld, aux_tx_busy, 1'(err_count != base_err)} !== 3'b000) begin
      miscompares++;
      $display("FAIL i2c_done: got vld=%b busy=%b errs=%0d want 0 0 0", aux_tx_vld, aux_tx_busy, err_count - base_err);
    end
  endtask

  task automatic test_native_rdy_toggle();
    logic [7:0] msg [3];
    logic       rdy_pat [5];
    int         exp_idx [5];
    int base_err, base_pop;
    msg = '{8'h90, 8'h00, 8'h00};
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_idx = '{0, 1, 1, 1, 2};
    base_err = err_count;
    for (int i = 0; i < 3; i++) begin
      native_msg_vld = 1'b1; native_splitted_msg = msg[i];
      tick();
    end
    native_msg_vld = 1'b0; native_splitted_msg = 8'h00;
    tick();
    base_pop = pop_count;
    for (int c = 0; c < 5; c++) begin
      aux_tx_rdy = rdy_pat[c];
      vectors++;
      if ({aux_tx_vld, aux_tx_data, aux_tx_last} !== {1'b1, msg[exp_idx[c]], (exp_idx[c] == 2)}) begin
        miscompares++;
        $display("FAIL native_hold[%0d]: got vld=%b data=%h last=%b want 1 %h %b",
                 c, aux_tx_vld, aux_tx_data, aux_tx_last, msg[exp_idx[c]], (exp_idx[c] == 2));
      end
      tick();
    end
    aux_tx_rdy = 1'b0;
    vectors++;
    if (pop_count - base_pop !== 3) begin
      miscompares++; $display("FAIL native_pops: got %0d want 3", pop_count - base_pop);
    end
    vectors++;
    if ({aux_tx_vld, aux_tx_src, 1'(err_count != base_err)} !== 3'b000) begin
      miscompares++;
      $display("FAIL native_done: got vld=%b src=%b errs=%0d want 0 0 0", aux_tx_vld, aux_tx_src, err_count - base_err);
    end
  endtask

  task automatic test_both_valid();
    logic [7:0] msg [3];
    int base_err;
    msg = '{8'hA1, 8'hA2, 8'hA3};
    base_err = err_count;
    native_msg_vld = 1'b1; native_splitted_msg = msg[0];
    i2c_msg_vld = 1'b1; i2c_splitted_msg = 8'hFF;
    tick();
    vectors++;
    if ({aux_tx_err, aux_tx_src} !== 2'b10) begin
      miscompares++; $display("FAIL tie_err: got err=%b src=%b want 1 0", aux_tx_err, aux_tx_src);
    end
    i2c_msg_vld = 1'b0; i2c_splitted_msg = 8'h00; native_splitted_msg = msg[1];
    tick();
    vectors++;
    if (aux_tx_err !== 1'b0) begin
      miscompares++; $display("FAIL tie_err_width: got err=%b want 0", aux_tx_err);
    end
    native_splitted_msg = msg[2];
    tick();
    native_msg_vld = 1'b0; native_splitted_msg = 8'h00; aux_tx_rdy = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({aux_tx_vld, aux_tx_data, aux_tx_last} !== {1'b1, msg[i], (i == 2)}) begin
        miscompares++;
        $display("FAIL tie_byte[%0d]: got vld=%b data=%h last=%b want 1 %h %b",
                 i, aux_tx_vld, aux_tx_data, aux_tx_last, msg[i], (i == 2));
      end
      tick();
    end
    aux_tx_rdy = 1'b0;
    vectors++;
    if (err_count - base_err !== 1 || aux_tx_vld !== 1'b0) begin
      miscompares++; $display("FAIL tie_done: got errs=%0d vld=%b want 1 0", err_count - base_err, aux_tx_vld);
    end
  endtask

  task automatic test_overflow();
    int base_err, base_vld;
    base_err = err_count;
    base_vld = vld_seen;
    for (int i = 0; i < 33; i++) begin
      i2c_msg_vld = 1'b1; i2c_splitted_msg = 8'(i + 1);
      tick();
    end
    i2c_msg_vld = 1'b0; i2c_splitted_msg = 8'h00;
    vectors++;
    if ({aux_tx_err, aux_tx_busy} !== 2'b10) begin
      miscompares++; $display("FAIL ovf_err: got err=%b busy=%b want 1 0", aux_tx_err, aux_tx_busy);
    end
    tick(); tick(); tick();
    vectors++;
    if (err_count - base_err !== 1 || vld_seen - base_vld !== 0) begin
      miscompares++;
      $display("FAIL ovf_counts: got errs=%0d vld_cycles=%0d want 1 0", err_count - base_err, vld_seen - base_vld);
    end
    vectors++;
    if (dut.u_fifo.count !== 6'd0 || aux_tx_busy !== 1'b0) begin
      miscompares++; $display("FAIL ovf_flush: got count=%0d busy=%b want 0 0", dut.u_fifo.count, aux_tx_busy);
    end
  endtask

  task automatic test_reset_mid_send();
    logic [7:0] msg [4];
    msg = '{8'h21, 8'h22, 8'h23, 8'h24};
    for (int i = 0; i < 5; i++) begin
      native_msg_vld = 1'b1; native_splitted_msg = 8'(8'h11 + i);
      tick();
    end
    native_msg_vld = 1'b0; native_splitted_msg = 8'h00; aux_tx_rdy = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({aux_tx_vld, aux_tx_data} !== {1'b1, 8'(8'h11 + i)}) begin
        miscompares++;
        $display("FAIL rstmid_byte[%0d]: got vld=%b data=%h want 1 %h", i, aux_tx_vld, aux_tx_data, 8'(8'h11 + i));
      end
      tick();
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({aux_tx_data, aux_tx_vld, aux_tx_last, aux_tx_src, aux_tx_busy, aux_tx_err} !== 13'h0) begin
      miscompares++;
      $display("FAIL rstmid_outputs: got data=%h vld=%b last=%b busy=%b want all 0",
               aux_tx_data, aux_tx_vld, aux_tx_last, aux_tx_busy);
    end
    aux_tx_rdy = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      i2c_msg_vld = 1'b1; i2c_splitted_msg = msg[i];
      tick();
    end
    i2c_msg_vld = 1'b0; i2c_splitted_msg = 8'h00; aux_tx_rdy = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({aux_tx_vld, aux_tx_data, aux_tx_last, aux_tx_src} !== {1'b1, msg[i], (i == 3), 1'b1}) begin
        miscompares++;
        $display("FAIL rstmid_next[%0d]: got vld=%b data=%h last=%b src=%b want 1 %h %b 1",
                 i, aux_tx_vld, aux_tx_data, aux_tx_last, aux_tx_src, msg[i], (i == 3));
      end
      tick();
    end
    aux_tx_rdy = 1'b0;
    vectors++;
    if (aux_tx_vld !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_end: got vld=%b want 0", aux_tx_vld);
    end
  endtask

  task automatic test_short_msg();
    int base_err, base_vld;
    base_err = err_count;
    base_vld = vld_seen;
    native_msg_vld = 1'b1; native_splitted_msg = 8'h30;
    tick();
    native_splitted_msg = 8'h31;
    tick();
    native_msg_vld = 1'b0; native_splitted_msg = 8'h00; aux_tx_rdy = 1'b1;
    tick();
`ifdef AUX_TX_MIN_LEN_EN
    vectors++;
    if ({aux_tx_vld, aux_tx_err, aux_tx_busy} !== 3'b010) begin
      miscompares++;
      $display("FAIL short_drop: got vld=%b err=%b busy=%b want 0 1 0", aux_tx_vld, aux_tx_err, aux_tx_busy);
    end
    tick(); tick();
    vectors++;
    if (err_count - base_err !== 1 || vld_seen - base_vld !== 0) begin
      miscompares++;
      $display("FAIL short_counts: got errs=%0d vld_cycles=%0d want 1 0", err_count - base_err, vld_seen - base_vld);
    end
`else
    vectors++;
    if ({aux_tx_vld, aux_tx_data, aux_tx_last} !== {1'b1, 8'h30, 1'b0}) begin
      miscompares++;
      $display("FAIL short_byte0: got vld=%b data=%h last=%b want 1 30 0", aux_tx_vld, aux_tx_data, aux_tx_last);
    end
    tick();
    vectors++;
    if ({aux_tx_vld, aux_tx_data, aux_tx_last} !== {1'b1, 8'h31, 1'b1}) begin
      miscompares++;
      $display("FAIL short_byte1: got vld=%b data=%h last=%b want 1 31 1", aux_tx_vld, aux_tx_data, aux_tx_last);
    end
    tick();
    vectors++;
    if (aux_tx_vld !== 1'b0 || err_count - base_err !== 0 || vld_seen - base_vld !== 2) begin
      miscompares++;
      $display("FAIL short_done: got vld=%b errs=%0d vld_cycles=%0d want 0 0 2",
               aux_tx_vld, err_count - base_err, vld_seen - base_vld);
    end
`endif
    aux_tx_rdy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_i2c_msg();
    test_native_rdy_toggle();
    test_both_valid();
    test_overflow();
    test_reset_mid_send();
    test_short_msg();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at %0t want completion", $time);
    $fatal(1);
  end

endmodule
